// File: rtl/writeback_arbiter.sv
// Writeback stage: merges SC, MC and dcache results onto one register-file
// write port, aligns loads and raises the pipeline rollback request.
module writeback_arbiter #(
  parameter  int NUM_LANES   = 16,
  parameter  int NUM_THREADS = 4,
  parameter  int LINE_BYTES  = 64,
  parameter  int PEND_DEPTH  = 4,
  localparam int TID_W       = $clog2(NUM_THREADS),
  localparam int VW          = NUM_LANES * 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sc_valid,
  input  logic [TID_W-1:0]        sc_tid,
  input  logic [4:0]              sc_reg,
  input  logic                    sc_has_dest,
  input  logic                    sc_is_vector,
  input  logic [NUM_LANES-1:0]    sc_mask,
  input  logic [VW-1:0]           sc_result,
  input  logic                    sc_rollback_en,
  input  logic [31:0]             sc_rollback_pc,
  input  logic                    mc_valid,
  input  logic [TID_W-1:0]        mc_tid,
  input  logic [4:0]              mc_reg,
  input  logic                    mc_has_dest,
  input  logic                    mc_is_vector,
  input  logic [NUM_LANES-1:0]    mc_mask,
  input  logic [VW-1:0]           mc_result,
  input  logic                    dd_valid,
  input  logic [TID_W-1:0]        dd_tid,
  input  logic [4:0]              dd_reg,
  input  logic                    dd_has_dest,
  input  logic                    dd_is_vector,
  input  logic [NUM_LANES-1:0]    dd_mask,
  input  logic                    dd_rollback_en,
  input  logic [31:0]             dd_rollback_pc,
  input  logic                    dd_is_load,
  input  logic [3:0]              dd_mem_op,
  input  logic [31:0]             dd_addr,
  input  logic [LINE_BYTES*8-1:0] dd_line,
  output logic                    mc_ready,
  output logic                    wb_rollback_en,
  output logic [TID_W-1:0]        wb_rollback_tid,
  output logic [31:0]             wb_rollback_pc,
  output logic                    wb_en,
  output logic [TID_W-1:0]        wb_tid,
  output logic [4:0]              wb_reg,
  output logic                    wb_is_vector,
  output logic [NUM_LANES-1:0]    wb_mask,
  output logic [VW-1:0]           wb_value,
  output logic                    wb_pend_full
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(PEND_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] MEM_B           = 4'd0;
  localparam logic [3:0] MEM_BX          = 4'd1;
  localparam logic [3:0] MEM_S           = 4'd2;
  localparam logic [3:0] MEM_SX          = 4'd3;
  localparam logic [3:0] MEM_L           = 4'd4;
  localparam logic [3:0] MEM_SYNC        = 4'd5;
  localparam logic [3:0] MEM_CONTROL_REG = 4'd6;
  localparam logic [3:0] MEM_BLOCK       = 4'd7;
  localparam logic [3:0] MEM_BLOCK_M     = 4'd8;
  localparam logic [3:0] MEM_BLOCK_IM    = 4'd9;

  typedef struct packed {
    logic [TID_W-1:0]     tid;
    logic [4:0]           rd;
    logic                 vec;
    logic [NUM_LANES-1:0] mask;
    logic [VW-1:0]        value;
  } entry_t;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic dd_rb, sc_rb, sc_squash, dd_cand, sc_cand;

  // DD is the older instruction, so its rollback wins and kills same-thread SC
  assign dd_rb     = dd_valid && dd_rollback_en;
  assign sc_rb     = sc_valid && (sc_rollback_en ||
                     (sc_has_dest && sc_reg == 5'd31));
  assign sc_squash = dd_rb && sc_valid && (sc_tid == dd_tid);
  assign dd_cand   = dd_valid && !dd_rb && dd_has_dest;
  assign sc_cand   = sc_valid && !sc_rb && !sc_squash && sc_has_dest;

  assign wb_rollback_en  = dd_rb || sc_rb;
  assign wb_rollback_tid = dd_rb ? dd_tid : sc_tid;
  assign wb_rollback_pc  = dd_rb          ? dd_rollback_pc :
                           sc_rollback_en ? sc_rollback_pc :
                                            sc_result[31:0];

  logic [31:0] line_w [NUM_LANES];
  logic [VW-1:0] blk_val;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign line_w[i]           = dd_line[(NUM_LANES-1-i)*32 +: 32];
    assign blk_val[i*32 +: 32] = bswap(line_w[i]);
  end

  logic [31:0] word, sval;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        is_blk, op_ok;
  logic        unused_addr;

  assign unused_addr = ^dd_addr[31:2+LW];
  assign word = line_w[dd_addr[2 +: LW]];
  assign hsel = dd_addr[1] ? {word[7:0], word[15:8]}
                           : {word[23:16], word[31:24]};

  always_comb begin
    case (dd_addr[1:0])
      2'd0:    bsel = word[31:24];
      2'd1:    bsel = word[23:16];
      2'd2:    bsel = word[15:8];
      default: bsel = word[7:0];
    endcase
  end

  always_comb begin
    sval   = '0;
    is_blk = 1'b0;
    op_ok  = 1'b1;
    case (dd_mem_op)
      MEM_B:  sval = {24'd0, bsel};
      MEM_BX: sval = {{24{bsel[7]}}, bsel};
      MEM_S:  sval = {16'd0, hsel};
      MEM_SX: sval = {{16{hsel[15]}}, hsel};
      MEM_L, MEM_SYNC, MEM_CONTROL_REG: sval = bswap(word);
      MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM: is_blk = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  entry_t dd_e, sc_e, mc_e;

  assign sc_e = {sc_tid, sc_reg, sc_is_vector, sc_mask, sc_result};
  assign mc_e = {mc_tid, mc_reg, mc_is_vector, mc_mask, mc_result};

  always_comb begin
    dd_e.tid   = dd_tid;
    dd_e.rd    = dd_reg;
    dd_e.vec   = dd_is_vector;
    dd_e.mask  = dd_mask;
    dd_e.value = '0;
    if (dd_is_load && is_blk) begin
      dd_e.value = blk_val;
    end else if (dd_is_load) begin
      dd_e.value = {NUM_LANES{sval}};
      dd_e.mask  = '1;
    end
  end

  entry_t        mem_q [PEND_DEPTH];
  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] cnt_q;
  logic          empty;

  assign empty        = (cnt_q == '0);
  assign mc_ready     = empty && !dd_cand && !sc_cand && !reset;
  assign wb_pend_full = (cnt_q >= CW'(PEND_DEPTH - 1));

  entry_t gnt_e, p0_e, p1_e;
  logic   gnt_v, pop, p0_v, p1_v;

  always_comb begin
    gnt_v = 1'b0;
    gnt_e = mc_e;
    pop   = 1'b0;
    p0_v  = 1'b0;
    p0_e  = sc_e;
    p1_v  = 1'b0;
    p1_e  = sc_e;
    if (!empty) begin
      gnt_v = 1'b1;
      gnt_e = mem_q[rptr_q];
      pop   = 1'b1;
      p0_v  = dd_cand || sc_cand;
      p0_e  = dd_cand ? dd_e : sc_e;
      p1_v  = dd_cand && sc_cand;
    end else if (dd_cand) begin
      gnt_v = 1'b1;
      gnt_e = dd_e;
      p0_v  = sc_cand;
    end else if (sc_cand) begin
      gnt_v = 1'b1;
      gnt_e = sc_e;
    end else if (mc_valid && mc_ready) begin
      gnt_v = mc_has_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (p0_v) mem_q[wptr_q] <= p0_e;
    if (p1_v) mem_q[wptr_q + PW'(1)] <= p1_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      wb_en        <= 1'b0;
      wb_tid       <= '0;
      wb_reg       <= '0;
      wb_is_vector <= 1'b0;
      wb_mask      <= '0;
      wb_value     <= '0;
    end else begin
      rptr_q       <= rptr_q + PW'(pop);
      wptr_q       <= wptr_q + PW'(p0_v) + PW'(p1_v);
      cnt_q        <= cnt_q + CW'(p0_v) + CW'(p1_v) - CW'(pop);
      wb_en        <= gnt_v;
      wb_tid       <= gnt_e.tid;
      wb_reg       <= gnt_e.rd;
      wb_is_vector <= gnt_e.vec;
      wb_mask      <= gnt_e.mask;
      wb_value     <= gnt_e.value;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(cnt_q) + int'(p0_v) + int'(p1_v) - int'(pop) <= PEND_DEPTH)
        else $error("pending FIFO overflow");
      assert (!(dd_valid && dd_is_load && !op_ok))
        else $error("unknown dd_mem_op %0d", dd_mem_op);
    end
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Parametrised writeback stage that merges completed results from three execution sources into one register-file write port per cycle:
  - single-cycle arithmetic (SC)
  - multi-cycle arithmetic (MC)
  - dcache data stage (DD)
- Performs load alignment, sign extension and endian swap. Generates the single rollback request for the pipeline.
- Buffers colliding SC/DD results in a small pending FIFO, so non-stallable sources never drop a result.

Parameters:
NUM_LANES, 16, vector lanes; wb_value is NUM_LANES*32 bits
NUM_THREADS, 4, hardware threads; TID_W = $clog2(NUM_THREADS)
LINE_BYTES, 64, dcache line size; must equal NUM_LANES*4
PEND_DEPTH, 4, pending FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
sc_valid/mc_valid/dd_valid  in  1 each  source result valid
sc_tid/mc_tid/dd_tid  in  TID_W each  thread index
sc_reg/mc_reg/dd_reg  in  5 each  dest register (31 = PC)
sc_has_dest/mc_has_dest/dd_has_dest  in  1 each  writes a register
sc_is_vector/mc_is_vector/dd_is_vector  in  1 each  vector dest
sc_mask/mc_mask/dd_mask  in  NUM_LANES each  lane write mask
sc_result/mc_result  in  NUM_LANES*32 each  computed value
sc_rollback_en/dd_rollback_en  in  1 each  branch taken / cache miss
sc_rollback_pc/dd_rollback_pc  in  32 each  restart PC
dd_is_load  in  1  DD carries a load
dd_mem_op  in  4  MEM_B, MEM_BX, MEM_S, MEM_SX, MEM_L, MEM_SYNC, MEM_CONTROL_REG, MEM_BLOCK(_M/_IM)
dd_addr  in  32  request byte address
dd_line  in  LINE_BYTES*8  line data, word 0 in MSBs, big-endian
mc_ready  out  1  MC result accepted this cycle
wb_rollback_en  out  1  combinational rollback
wb_rollback_tid  out  TID_W  rollback thread
wb_rollback_pc  out  32  restart PC
wb_en  out  1  registered write enable
wb_tid  out  TID_W  write thread
wb_reg  out  5  write register
wb_is_vector  out  1  vector write
wb_mask  out  NUM_LANES  lane mask
wb_value  out  NUM_LANES*32  write data
wb_pend_full  out  1  FIFO count >= PEND_DEPTH-1; thread select stops issue

Behaviour:
- Reset: all registered outputs 0, FIFO empty, mc_ready=0.
- Rollback (combinational):
  - DD rollback has priority over SC rollback (DD is the older instruction).
  - SC rollback fires on sc_rollback_en, or on sc_has_dest with sc_reg==31; PC = sc_rollback_pc or sc_result lane 0 respectively.
  - Rollback source entry never writes the register file and never enters the FIFO.
  - If DD rolls back and SC is valid with the same tid, the SC entry is squashed too.
- Candidates: a valid, non-rollback source with has_dest=1. Valid entries with has_dest=0 are discarded.
- Write port grant priority each cycle: FIFO head > DD > SC > MC.
  - DD/SC candidates not granted are pushed to the FIFO in the same cycle, DD before SC.
  - Push capacity is 2 per cycle.
- mc_ready = FIFO empty && no DD/SC candidate && !reset. An MC result is held by the source until mc_ready.
- Write latency: the granted entry appears on wb_* on the next clock edge, 1 cycle. wb_en=0 on cycles with no grant.
- FIFO:
  - Entries store the already-aligned value.
  - Pointers wrap modulo PEND_DEPTH.
  - Push plus pop in the same cycle is legal.
  - Overflow is an assertion failure; wb_pend_full guarantees 2 free slots.
- DD load alignment, lane word = dd_line[(NUM_LANES-1-addr[2+:log2 NUM_LANES])*32 +: 32]:
  - MEM_B/BX: byte selected by addr[1:0] (00 = bits 31:24); zero- or sign-extended.
  - MEM_S/SX: halfword selected by addr[1], bytes swapped; zero- or sign-extended.
  - MEM_L/SYNC/CONTROL_REG: full word, byte-reversed.
  - Scalar loads broadcast to all lanes, mask all ones.
  - MEM_BLOCK*: every word byte-reversed, mask = dd_mask.
  - DD non-load with has_dest writes 0.
  - Unknown op asserts.
- Reset mid-operation: FIFO flushed, in-flight entries lost. Upstream is reset concurrently.

Test Plan:
- SC only: sc_reg=3, tid 1, result lane0=0x12345678, mask 0x0001 -> next cycle wb_en=1, wb_reg=3, wb_tid=1, wb_value lane0=0x12345678; following cycle wb_en=0.
- DD MEM_BX at addr 0x1003, line word for that address = 0x000000F0 -> wb_value all lanes 0xFFFFFFF0, mask 0xFFFF. Same with MEM_B -> 0x000000F0. MEM_SX at addr 0x1002, same word -> 0xFFFFF000.
- SC and DD same cycle, FIFO empty, MC valid -> cycle+1 DD write; cycle+2 SC write from FIFO; mc_ready=0 until FIFO empties, then MC written at cycle+3.
- sc_reg=31, result 0x400 -> wb_rollback_en=1, pc 0x400 same cycle; wb_en stays 0. Simultaneous dd_rollback_en, pc 0x800, same tid -> pc 0x800, SC squashed.
- Back-to-back SC+DD collisions with PEND_DEPTH=4 -> wb_pend_full asserts at count 3; no overflow assertion; FIFO drains in order, one entry per cycle.
- Reset asserted with 3 FIFO entries -> next cycle count 0, wb_en=0, mc_ready=0.
